// File: rtl/snake_pkg.sv
// Shared snake encodings: direction codes and game FSM states.
// Used by the sequencer, the position datapath and the display logic.
package snake_pkg;

  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_UP    = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_SPAWN = 3'd2,
    ST_OVER  = 3'd3,
    ST_PAUSE = 3'd4
  } state_e;

  // Opposite directions differ only in bit 0.
  function automatic logic [1:0] dir_reverse(input logic [1:0] d);
    return {d[1], ~d[0]};
  endfunction

endpackage

// File: rtl/snake_dir_queue.sv
// Two-entry direction-command FIFO with button edge detection, fixed
// priority (right > left > up > down) and a same/reverse direction filter.
module snake_dir_queue
  import snake_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic [1:0] last_dir,
  input  logic       pop,
  output logic [1:0] head,
  output logic       valid
);

  logic [3:0] btn, btn_q, rise;
  logic [1:0] q_q [2];
  logic [1:0] q_d [2];
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] sel, tail;
  logic       push;

  assign btn  = {right, left, up, down};
  assign rise = btn & ~btn_q;

  always_comb begin
    sel = DIR_DOWN;
    if (rise[3])      sel = DIR_RIGHT;
    else if (rise[2]) sel = DIR_LEFT;
    else if (rise[1]) sel = DIR_UP;
  end

  // Filter against the most recently queued command, or the live direction when empty.
  assign tail = (cnt_q == 2'd2) ? q_q[1] : (cnt_q == 2'd1) ? q_q[0] : last_dir;
  assign push = en && (|rise) && (cnt_q != 2'd2) && (sel != tail) &&
                (sel != dir_reverse(tail));

  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    if (pop && cnt_q != 2'd0) begin
      q_d[0] = q_q[1];
      cnt_d  = cnt_q - 2'd1;
    end
    if (push) begin
      q_d[cnt_d[0]] = sel;
      cnt_d         = cnt_d + 2'd1;
    end
    if (clr) cnt_d = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q  <= 4'b0000;
      cnt_q  <= 2'd0;
      q_q[0] <= DIR_RIGHT;
      q_q[1] <= DIR_RIGHT;
    end else begin
      btn_q <= btn;
      cnt_q <= cnt_d;
      q_q   <= q_d;
    end
  end

  assign head  = q_q[0];
  assign valid = (cnt_q != 2'd0);

endmodule

// File: rtl/snake_game_sequencer.sv
// Snake game FSM: movement tick, apple respawn handshake, length and score.
// Optional macro SNAKE_PAUSE_EN: start edges toggle RUN <-> PAUSE.
module snake_game_sequencer
  import snake_pkg::*;
#(
  parameter int unsigned TICK_DIV = 2500000,
  parameter int unsigned MAX_LEN  = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       apple_hit,
  input  logic       collide_self,
  input  logic       spawn_ack,
  output logic       step,
  output logic       grow,
  output logic [1:0] dir,
  output logic       spawn_req,
  output logic [4:0] body_len,
  output logic [5:0] score,
  output logic       game_over,
  output logic [2:0] state
);

  localparam int unsigned     CntW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);
  localparam logic [4:0]      LenMax  = 5'(MAX_LEN);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            start_q, start_rise, pause_tog, tick;
  logic            q_clr, q_en, q_pop, q_valid;
  logic [1:0]      q_head, dir_q;
  logic            step_q, grow_q, spawn_req_q, game_over_q;
  logic [4:0]      len_q;
  logic [5:0]      score_q;

  assign start_rise = start & ~start_q;
  assign tick       = (cnt_q == CntLast);

`ifdef SNAKE_PAUSE_EN
  assign pause_tog = start_rise;
`else
  assign pause_tog = 1'b0;
`endif

  assign q_clr = start_rise && (state_q == ST_IDLE || state_q == ST_OVER);
  assign q_en  = (state_q == ST_RUN) || (state_q == ST_SPAWN);
  // Pop exactly when the RUN branch below issues a step.
  assign q_pop = (state_q == ST_RUN) && !collide_self && !apple_hit && !pause_tog && tick;

  snake_dir_queue u_dir_queue (
    .clk      (clk),
    .rst      (rst),
    .clr      (q_clr),
    .en       (q_en),
    .up       (up),
    .down     (down),
    .left     (left),
    .right    (right),
    .last_dir (dir_q),
    .pop      (q_pop),
    .head     (q_head),
    .valid    (q_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      start_q     <= 1'b0;
      dir_q       <= DIR_RIGHT;
      step_q      <= 1'b0;
      grow_q      <= 1'b0;
      spawn_req_q <= 1'b0;
      game_over_q <= 1'b0;
      len_q       <= 5'd0;
      score_q     <= 6'd0;
    end else begin
      start_q <= start;
      step_q  <= 1'b0;
      grow_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_OVER: begin
          if (start_rise) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            dir_q       <= DIR_RIGHT;
            len_q       <= 5'd0;
            score_q     <= 6'd0;
            game_over_q <= 1'b0;
            spawn_req_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (collide_self) begin
            state_q     <= ST_OVER;
            game_over_q <= 1'b1;
          end else if (apple_hit) begin
            state_q     <= ST_SPAWN;
            grow_q      <= 1'b1;
            spawn_req_q <= 1'b1;
            if (len_q < LenMax) len_q <= len_q + 5'd1;
            if (score_q != 6'd63) score_q <= score_q + 6'd1;
          end else if (pause_tog) begin
            state_q <= ST_PAUSE;
          end else if (tick) begin
            cnt_q  <= '0;
            step_q <= 1'b1;
            if (q_valid) dir_q <= q_head;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        ST_SPAWN: begin
          if (collide_self) begin
            state_q     <= ST_OVER;
            game_over_q <= 1'b1;
            spawn_req_q <= 1'b0;
          end else if (spawn_ack && spawn_req_q) begin
            state_q     <= ST_RUN;
            spawn_req_q <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (pause_tog) state_q <= ST_RUN;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign step      = step_q;
  assign grow      = grow_q;
  assign dir       = dir_q;
  assign spawn_req = spawn_req_q;
  assign body_len  = len_q;
  assign score     = score_q;
  assign game_over = game_over_q;
  assign state     = state_q;

endmodule

// File: tb/tb_snake_game_sequencer.sv
// Directed bench for snake_game_sequencer with TICK_DIV=4, MAX_LEN=3.
module tb_snake_game_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, up, down, left, right;
  logic       apple_hit, collide_self, spawn_ack;
  logic       step, grow, spawn_req, game_over;
  logic [1:0] dir;
  logic [4:0] body_len;
  logic [5:0] score;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  snake_game_sequencer #(
    .TICK_DIV (4),
    .MAX_LEN  (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .up           (up),
    .down         (down),
    .left         (left),
    .right        (right),
    .apple_hit    (apple_hit),
    .collide_self (collide_self),
    .spawn_ack    (spawn_ack),
    .step         (step),
    .grow         (grow),
    .dir          (dir),
    .spawn_req    (spawn_req),
    .body_len     (body_len),
    .score        (score),
    .game_over    (game_over),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bounded wait for the next step pulse; returns on the negedge where step is seen.
  task automatic wait_step(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (step === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: step got 0 within 8 cycles, want 1", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; up = 0; down = 0; left = 0; right = 0;
    apple_hit = 0; collide_self = 0; spawn_ack = 0;
    cyc(2);
    rst = 1'b0;
    n_tests++;
    if ({state, dir, step, grow, spawn_req, game_over} !== {3'd0, 2'b00, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_ctrl: got state=%0d dir=%b step=%b grow=%b req=%b over=%b, want 0/00/0/0/0/0",
               state, dir, step, grow, spawn_req, game_over);
    end
    n_tests++;
    if ({body_len, score} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got len=%0d score=%0d, want 0/0", body_len, score);
    end
  endtask

  task automatic test_run_tick();
    start = 1'b1; cyc(1); start = 1'b0;
    n_tests++;
    if ({state, dir, body_len, step} !== {3'd1, 2'b00, 5'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL start_run: got state=%0d dir=%b len=%0d step=%b, want 1/00/0/0",
               state, dir, body_len, step);
    end
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      n_tests++;
      if (step !== ((i % 4) == 0)) begin
        n_fail++;
        $display("FAIL tick_%0d: got step=%b, want %b", i, step, (i % 4) == 0);
      end
    end
  endtask

  task automatic test_direction();
    wait_step("dir_sync");
    up = 1; cyc(1); up = 0; right = 1; cyc(1); right = 0;
    wait_step("dir_step1");
    n_tests++;
    if (dir !== 2'b10) begin
      n_fail++; $display("FAIL dir_up: got %b, want 10", dir);
    end
    wait_step("dir_step2");
    n_tests++;
    if (dir !== 2'b00) begin
      n_fail++; $display("FAIL dir_right: got %b, want 00", dir);
    end
    left = 1; cyc(1); left = 0;
    wait_step("dir_step3");
    n_tests++;
    if (dir !== 2'b00) begin
      n_fail++; $display("FAIL dir_reverse_drop: got %b, want 00", dir);
    end
  endtask

  task automatic test_queue_full();
    wait_step("full_sync");
    up = 1; cyc(1); up = 0; left = 1; cyc(1); left = 0; down = 1; cyc(1); down = 0;
    wait_step("full_step1");
    n_tests++;
    if (dir !== 2'b10) begin
      n_fail++; $display("FAIL full_first: got %b, want 10", dir);
    end
    wait_step("full_step2");
    n_tests++;
    if (dir !== 2'b01) begin
      n_fail++; $display("FAIL full_second: got %b, want 01", dir);
    end
    wait_step("full_step3");
    n_tests++;
    if (dir !== 2'b01) begin
      n_fail++; $display("FAIL full_drop: got %b, want 01", dir);
    end
  endtask

  task automatic test_priority();
    wait_step("prio_sync");
    up = 1; down = 1; cyc(1); up = 0; down = 0;
    wait_step("prio_step1");
    n_tests++;
    if (dir !== 2'b10) begin
      n_fail++; $display("FAIL prio_up: got %b, want 10", dir);
    end
    wait_step("prio_step2");
    n_tests++;
    if (dir !== 2'b10) begin
      n_fail++; $display("FAIL prio_single: got %b, want 10", dir);
    end
  endtask

  task automatic test_apple_spawn();
    wait_step("apple_sync");
    apple_hit = 1; cyc(1); apple_hit = 0;
    n_tests++;
    if ({grow, body_len, score, state, spawn_req} !== {1'b1, 5'd1, 6'd1, 3'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL apple_hit: got grow=%b len=%0d score=%0d state=%0d req=%b, want 1/1/1/2/1",
               grow, body_len, score, state, spawn_req);
    end
    for (int i = 1; i <= 5; i++) begin
      cyc(1);
      n_tests++;
      if ({step, grow, state, spawn_req} !== {2'b00, 3'd2, 1'b1}) begin
        n_fail++;
        $display("FAIL spawn_hold_%0d: got step=%b grow=%b state=%0d req=%b, want 0/0/2/1",
                 i, step, grow, state, spawn_req);
      end
    end
    spawn_ack = 1; cyc(1); spawn_ack = 0;
    n_tests++;
    if ({state, spawn_req} !== {3'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL spawn_ack: got state=%0d req=%b, want 1/0", state, spawn_req);
    end
    for (int i = 1; i <= 4; i++) begin
      cyc(1);
      n_tests++;
      if (step !== (i == 4)) begin
        n_fail++;
        $display("FAIL resume_%0d: got step=%b, want %b", i, step, i == 4);
      end
    end
  endtask

  task automatic test_saturation();
    for (int h = 2; h <= 4; h++) begin
      apple_hit = 1; cyc(1); apple_hit = 0;
      n_tests++;
      if ({body_len, score} !== {5'((h > 3) ? 3 : h), 6'(h)}) begin
        n_fail++;
        $display("FAIL sat_hit%0d: got len=%0d score=%0d, want %0d/%0d",
                 h, body_len, score, (h > 3) ? 3 : h, h);
      end
      spawn_ack = 1; cyc(1); spawn_ack = 0;
      n_tests++;
      if (state !== 3'd1) begin
        n_fail++; $display("FAIL sat_ack%0d: got state=%0d, want 1", h, state);
      end
    end
  endtask

  task automatic test_collision();
    apple_hit = 1; collide_self = 1; cyc(1); apple_hit = 0; collide_self = 0;
    n_tests++;
    if ({state, game_over, grow, score, body_len} !== {3'd3, 1'b1, 1'b0, 6'd4, 5'd3}) begin
      n_fail++;
      $display("FAIL collide: got state=%0d over=%b grow=%b score=%0d len=%0d, want 3/1/0/4/3",
               state, game_over, grow, score, body_len);
    end
    for (int i = 1; i <= 4; i++) begin
      cyc(1);
      n_tests++;
      if ({step, state, game_over} !== {1'b0, 3'd3, 1'b1}) begin
        n_fail++;
        $display("FAIL over_hold_%0d: got step=%b state=%0d over=%b, want 0/3/1",
                 i, step, state, game_over);
      end
    end
    up = 1; cyc(1); up = 0;
    start = 1; cyc(1); start = 0;
    n_tests++;
    if ({state, score, body_len, game_over, dir} !== {3'd1, 6'd0, 5'd0, 1'b0, 2'b00}) begin
      n_fail++;
      $display("FAIL restart: got state=%0d score=%0d len=%0d over=%b dir=%b, want 1/0/0/0/00",
               state, score, body_len, game_over, dir);
    end
    wait_step("restart_step");
    n_tests++;
    if (dir !== 2'b00) begin
      n_fail++; $display("FAIL restart_dir: got %b, want 00", dir);
    end
  endtask

  task automatic test_start_in_run();
    wait_step("srun_sync");
    start = 1; cyc(1); start = 0;
`ifdef SNAKE_PAUSE_EN
    n_tests++;
    if (state !== 3'd4) begin
      n_fail++; $display("FAIL pause_enter: got state=%0d, want 4", state);
    end
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      n_tests++;
      if (step !== 1'b0) begin
        n_fail++; $display("FAIL pause_hold_%0d: got step=%b, want 0", i, step);
      end
    end
    start = 1; cyc(1); start = 0;
    n_tests++;
    if (state !== 3'd1) begin
      n_fail++; $display("FAIL pause_exit: got state=%0d, want 1", state);
    end
    wait_step("pause_resume");
`else
    n_tests++;
    if (state !== 3'd1) begin
      n_fail++; $display("FAIL start_ignored: got state=%0d, want 1", state);
    end
    wait_step("start_ignored_step");
`endif
  endtask

  task automatic test_reset_mid_spawn();
    apple_hit = 1; cyc(1); apple_hit = 0;
    n_tests++;
    if ({state, spawn_req} !== {3'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL pre_rst_spawn: got state=%0d req=%b, want 2/1", state, spawn_req);
    end
    rst = 1; cyc(1);
    n_tests++;
    if ({state, spawn_req, body_len, score, grow} !== {3'd0, 1'b0, 5'd0, 6'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_spawn: got state=%0d req=%b len=%0d score=%0d grow=%b, want 0/0/0/0/0",
               state, spawn_req, body_len, score, grow);
    end
    rst = 0; cyc(1);
  endtask

  initial begin
    test_reset();
    test_run_tick();
    test_direction();
    test_queue_full();
    test_priority();
    test_apple_spawn();
    test_saturation();
    test_collision();
    test_start_in_run();
    test_reset_mid_spawn();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
